// File: rtl/cpu_types_pkg.sv
// Shared fetch/branch-prediction types and constants.
package cpu_types_pkg;

  typedef logic [1:0]  bp_hash_t;
  typedef logic [27:0] bp_tag_t;
  typedef logic [29:0] bp_target_t;
  typedef logic [1:0]  bp_ctr_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    HALTED   = 2'd2
  } fetch_state_t;

  localparam int          BP_ENTRIES = 4;
  localparam logic [31:0] PC_STEP    = 32'd4;

endpackage

// File: rtl/bp_counter_table.sv
// 2-bit saturating direction counters, one per BTB index.
// The read port and the update port both see pre-update values.
module bp_counter_table
  import cpu_types_pkg::*;
#(
  parameter bp_ctr_t CTR_INIT = 2'b01
) (
  input  logic     clk,
  input  logic     rst,
  input  bp_hash_t rd_idx,
  output bp_ctr_t  rd_ctr,
  input  logic     upd_en,
  input  bp_hash_t upd_idx,
  input  logic     upd_taken,
  output bp_ctr_t  upd_old
);

  bp_ctr_t ctr [BP_ENTRIES];

  assign rd_ctr  = ctr[rd_idx];
  assign upd_old = ctr[upd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BP_ENTRIES; i++) ctr[i] <= CTR_INIT;
    end else if (upd_en) begin
      if (upd_taken && upd_old != 2'b11)
        ctr[upd_idx] <= upd_old + 2'd1;
      else if (!upd_taken && upd_old != 2'b00)
        ctr[upd_idx] <= upd_old - 2'd1;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter owner: BTB/counter prediction, misprediction redirect, BTB write-back.
//   state    | meaning
//   RUN      | fetching; PC advances to the predicted target on each accepted fetch
//   REDIRECT | one bubble after a mispredict, corrected PC on imemaddr
//   HALTED   | fetch stopped and PC frozen until RST
module pc_fetch_unit
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC0      = 32'h0000_0000,
  parameter bp_ctr_t     CTR_INIT = 2'b01
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        stall,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_npc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output bp_hash_t    bp_hash_sel,
  output bp_tag_t     bp_tag_sel,
  input  logic        bp_hit,
  input  bp_target_t  bp_target,
  output logic        bp_WEN,
  output bp_hash_t    bp_hash_wsel,
  output bp_tag_t     bp_tag_n,
  output bp_target_t  bp_target_n,
  output logic        bp_active_n,
  input  logic        resolve_valid,
  input  logic [31:0] resolve_pc,
  input  logic        resolve_taken,
  input  logic [31:0] resolve_target,
  input  logic        resolve_pred_taken,
  input  logic [31:0] resolve_pred_target,
  output logic        mispredict
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next, pc_plus4, redirect_pc;
  bp_ctr_t      rd_ctr, upd_old;
  logic         target_miss, mispredict_raw, write_taken, write_invalidate;
  logic         unused_bits;

  bp_counter_table #(.CTR_INIT(CTR_INIT)) u_ctr (
    .clk      (CLK),
    .rst      (RST),
    .rd_idx   (pc[3:2]),
    .rd_ctr   (rd_ctr),
    .upd_en   (resolve_valid),
    .upd_idx  (resolve_pc[3:2]),
    .upd_taken(resolve_taken),
    .upd_old  (upd_old)
  );

  assign pc_plus4     = pc + PC_STEP;
  assign imemaddr     = pc;
  assign fetch_pc     = pc;
  assign fetch_npc    = pc_plus4;
  assign bp_hash_sel  = pc[3:2];
  assign bp_tag_sel   = pc[31:4];
  assign pred_taken   = bp_hit && rd_ctr[1];
  assign pred_target  = pred_taken ? {bp_target, 2'b00} : pc_plus4;
  assign unused_bits  = ^{resolve_pc[1:0], rd_ctr[0]};

  assign target_miss    = resolve_taken && (resolve_target != resolve_pred_target);
  assign mispredict_raw = resolve_valid && ((resolve_taken != resolve_pred_taken) || target_miss);
  assign mispredict     = mispredict_raw && (state != HALTED) && !halt && !RST;
  assign redirect_pc    = resolve_taken ? resolve_target : resolve_pc + PC_STEP;

  // Taken entries are (re)installed; a not-taken branch at a floored counter drops its entry.
  assign write_taken      = resolve_taken && (!resolve_pred_taken || target_miss);
  assign write_invalidate = !resolve_taken && (upd_old == 2'b00);
  assign bp_WEN           = resolve_valid && !RST && (write_taken || write_invalidate);
  assign bp_active_n      = resolve_taken;
  assign bp_hash_wsel     = resolve_pc[3:2];
  assign bp_tag_n         = resolve_pc[31:4];
  assign bp_target_n      = resolve_target[31:2];

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    imemREN     = 1'b1;
    fetch_valid = 1'b0;
    case (state)
      RUN: begin
        fetch_valid = ihit && !stall && !mispredict && !RST;
        if (halt) begin
          state_next = HALTED;
        end else if (mispredict) begin
          state_next = REDIRECT;
          pc_next    = redirect_pc;
        end else if (fetch_valid) begin
          pc_next = pred_target;
        end
      end
      REDIRECT: begin
        imemREN = 1'b0;
        if (halt) begin
          state_next = HALTED;
        end else if (mispredict) begin
          pc_next = redirect_pc;
        end else begin
          state_next = RUN;
        end
      end
      HALTED: imemREN = 1'b0;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
      pc    <= PC0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, prediction, redirect, stall, counter floor, halt.
module tb_pc_fetch_unit;
  logic        CLK = 1'b0;
  logic        RST, ihit, stall, halt, bp_hit;
  logic [29:0] bp_target;
  logic        resolve_valid, resolve_taken, resolve_pred_taken;
  logic [31:0] resolve_pc, resolve_target, resolve_pred_target;
  logic        imemREN, fetch_valid, pred_taken, bp_WEN, bp_active_n, mispredict;
  logic [31:0] imemaddr, fetch_pc, fetch_npc, pred_target;
  logic [1:0]  bp_hash_sel, bp_hash_wsel;
  logic [27:0] bp_tag_sel, bp_tag_n;
  logic [29:0] bp_target_n;
  int vectors = 0;
  int miscompares = 0;

  pc_fetch_unit dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .stall(stall), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr), .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc), .fetch_npc(fetch_npc), .pred_taken(pred_taken),
    .pred_target(pred_target), .bp_hash_sel(bp_hash_sel), .bp_tag_sel(bp_tag_sel),
    .bp_hit(bp_hit), .bp_target(bp_target), .bp_WEN(bp_WEN),
    .bp_hash_wsel(bp_hash_wsel), .bp_tag_n(bp_tag_n), .bp_target_n(bp_target_n),
    .bp_active_n(bp_active_n), .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .resolve_taken(resolve_taken), .resolve_target(resolve_target),
    .resolve_pred_taken(resolve_pred_taken), .resolve_pred_target(resolve_pred_target),
    .mispredict(mispredict)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  task automatic idle_inputs;
    ihit = 0; stall = 0; halt = 0; bp_hit = 0; bp_target = '0;
    resolve_valid = 0; resolve_pc = '0; resolve_taken = 0;
    resolve_target = '0; resolve_pred_taken = 0; resolve_pred_target = '0;
  endtask

  task automatic drive_resolve(input logic [31:0] rpc, input logic tk, input logic [31:0] tgt,
                               input logic ptk, input logic [31:0] ptgt);
    resolve_valid = 1; resolve_pc = rpc; resolve_taken = tk;
    resolve_target = tgt; resolve_pred_taken = ptk; resolve_pred_target = ptgt;
  endtask

  task automatic do_reset;
    idle_inputs(); RST = 1; tick(); tick(); RST = 0;
  endtask

  task automatic test_reset;
    idle_inputs(); RST = 1; ihit = 1;
    tick(); tick(); #1;
    vectors++; if (imemaddr !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want %h", imemaddr, 32'h0); end
    vectors++; if (imemREN !== 1'b1) begin miscompares++; $display("FAIL reset_ren: got %b want 1", imemREN); end
    vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL reset_fv: got %b want 0", fetch_valid); end
    vectors++; if (bp_WEN !== 1'b0) begin miscompares++; $display("FAIL reset_wen: got %b want 0", bp_WEN); end
    vectors++; if (mispredict !== 1'b0) begin miscompares++; $display("FAIL reset_mp: got %b want 0", mispredict); end
    RST = 0; ihit = 0;
  endtask

  task automatic test_sequential;
    do_reset(); ihit = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (imemaddr !== 32'(i * 4)) begin miscompares++; $display("FAIL seq_pc[%0d]: got %h want %h", i, imemaddr, 32'(i * 4)); end
      vectors++; if (fetch_valid !== 1'b1) begin miscompares++; $display("FAIL seq_fv[%0d]: got %b want 1", i, fetch_valid); end
      tick();
    end
    ihit = 0; #1;
    vectors++; if (imemaddr !== 32'hC) begin miscompares++; $display("FAIL seq_end: got %h want %h", imemaddr, 32'hC); end
  endtask

  task automatic test_predict;
    do_reset(); bp_hit = 1; bp_target = 30'h40;
    drive_resolve(32'h0, 1, 32'h100, 1, 32'h100); #1;
    vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL pred_same_cycle: got %b want 0", pred_taken); end
    vectors++; if (bp_WEN !== 1'b0) begin miscompares++; $display("FAIL pred_correct_wen: got %b want 0", bp_WEN); end
    vectors++; if (mispredict !== 1'b0) begin miscompares++; $display("FAIL pred_correct_mp: got %b want 0", mispredict); end
    tick(); #1;
    vectors++; if (pred_taken !== 1'b1) begin miscompares++; $display("FAIL pred_ctr10: got %b want 1", pred_taken); end
    tick(); resolve_valid = 0; #1;
    vectors++; if (pred_target !== 32'h100) begin miscompares++; $display("FAIL pred_target: got %h want %h", pred_target, 32'h100); end
    ihit = 1; tick(); ihit = 0; #1;
    vectors++; if (imemaddr !== 32'h100) begin miscompares++; $display("FAIL pred_next_pc: got %h want %h", imemaddr, 32'h100); end
    // counter is at 11: one more taken must saturate, so one not-taken leaves 10
    drive_resolve(32'h0, 1, 32'h100, 1, 32'h100); tick();
    drive_resolve(32'h0, 0, 32'h0, 0, 32'h0); tick(); resolve_valid = 0; #1;
    vectors++; if (pred_taken !== 1'b1) begin miscompares++; $display("FAIL pred_sat_top: got %b want 1", pred_taken); end
    do_reset(); ihit = 1; bp_hit = 1; bp_target = 30'h40; #1;
    vectors++; if (pred_target !== 32'h4) begin miscompares++; $display("FAIL pred_weak_target: got %h want %h", pred_target, 32'h4); end
    tick(); ihit = 0; bp_hit = 0; #1;
    vectors++; if (imemaddr !== 32'h4) begin miscompares++; $display("FAIL pred_weak_pc: got %h want %h", imemaddr, 32'h4); end
  endtask

  task automatic test_mispredict;
    do_reset(); ihit = 1;
    drive_resolve(32'h10, 1, 32'h200, 0, 32'h14); #1;
    vectors++; if (mispredict !== 1'b1) begin miscompares++; $display("FAIL mp_flag: got %b want 1", mispredict); end
    vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL mp_fv: got %b want 0", fetch_valid); end
    vectors++; if (bp_WEN !== 1'b1) begin miscompares++; $display("FAIL mp_wen: got %b want 1", bp_WEN); end
    vectors++; if (bp_hash_wsel !== 2'd0) begin miscompares++; $display("FAIL mp_wsel: got %h want 0", bp_hash_wsel); end
    vectors++; if (bp_tag_n !== 28'h1) begin miscompares++; $display("FAIL mp_tag: got %h want 1", bp_tag_n); end
    vectors++; if (bp_target_n !== 30'h80) begin miscompares++; $display("FAIL mp_target: got %h want 80", bp_target_n); end
    vectors++; if (bp_active_n !== 1'b1) begin miscompares++; $display("FAIL mp_active: got %b want 1", bp_active_n); end
    tick(); resolve_valid = 0; #1;
    vectors++; if (imemaddr !== 32'h200) begin miscompares++; $display("FAIL mp_bubble_pc: got %h want %h", imemaddr, 32'h200); end
    vectors++; if (imemREN !== 1'b0) begin miscompares++; $display("FAIL mp_bubble_ren: got %b want 0", imemREN); end
    vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL mp_bubble_fv: got %b want 0", fetch_valid); end
    tick(); #1;
    vectors++; if (imemREN !== 1'b1) begin miscompares++; $display("FAIL mp_resume_ren: got %b want 1", imemREN); end
    vectors++; if (fetch_valid !== 1'b1) begin miscompares++; $display("FAIL mp_resume_fv: got %b want 1", fetch_valid); end
    tick(); #1;
    vectors++; if (imemaddr !== 32'h204) begin miscompares++; $display("FAIL mp_resume_pc: got %h want %h", imemaddr, 32'h204); end
    ihit = 0;
    drive_resolve(32'h40, 1, 32'h500, 1, 32'h600); #1;
    vectors++; if (mispredict !== 1'b1 || bp_WEN !== 1'b1) begin miscompares++; $display("FAIL mp_tgt_miss: got mp=%b wen=%b want 1 1", mispredict, bp_WEN); end
    tick(); resolve_valid = 0; #1;
    vectors++; if (imemaddr !== 32'h500) begin miscompares++; $display("FAIL mp_tgt_pc: got %h want %h", imemaddr, 32'h500); end
    tick();
  endtask

  task automatic test_stall;
    do_reset(); ihit = 1; stall = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL stall_fv[%0d]: got %b want 0", i, fetch_valid); end
      tick();
    end
    #1;
    vectors++; if (imemaddr !== 32'h0) begin miscompares++; $display("FAIL stall_pc: got %h want %h", imemaddr, 32'h0); end
    drive_resolve(32'h20, 0, 32'h0, 1, 32'h100); #1;
    vectors++; if (mispredict !== 1'b1 || bp_WEN !== 1'b0) begin miscompares++; $display("FAIL stall_mp: got mp=%b wen=%b want 1 0", mispredict, bp_WEN); end
    tick(); resolve_valid = 0; #1;
    vectors++; if (imemaddr !== 32'h24 || imemREN !== 1'b0) begin miscompares++; $display("FAIL stall_redir: got pc=%h ren=%b want 24 0", imemaddr, imemREN); end
    stall = 0; tick(); #1;
    vectors++; if (fetch_valid !== 1'b1 || imemaddr !== 32'h24) begin miscompares++; $display("FAIL stall_resume: got fv=%b pc=%h want 1 24", fetch_valid, imemaddr); end
    tick(); ihit = 0; #1;
    vectors++; if (imemaddr !== 32'h28) begin miscompares++; $display("FAIL stall_next: got %h want %h", imemaddr, 32'h28); end
  endtask

  task automatic test_ctr_floor;
    do_reset(); bp_hit = 1; bp_target = 30'h40;
    drive_resolve(32'h30, 0, 32'h0, 0, 32'h0); #1;
    vectors++; if (bp_WEN !== 1'b0) begin miscompares++; $display("FAIL floor_first_wen: got %b want 0", bp_WEN); end
    tick(); #1;
    vectors++; if (bp_WEN !== 1'b1 || bp_active_n !== 1'b0) begin miscompares++; $display("FAIL floor_inval: got wen=%b act=%b want 1 0", bp_WEN, bp_active_n); end
    vectors++; if (bp_tag_n !== 28'h3 || bp_hash_wsel !== 2'd0) begin miscompares++; $display("FAIL floor_addr: got tag=%h idx=%h want 3 0", bp_tag_n, bp_hash_wsel); end
    vectors++; if (mispredict !== 1'b0) begin miscompares++; $display("FAIL floor_mp: got %b want 0", mispredict); end
    tick(); #1;
    vectors++; if (bp_WEN !== 1'b1) begin miscompares++; $display("FAIL floor_stays00: got %b want 1", bp_WEN); end
    tick();
    drive_resolve(32'h30, 1, 32'h80, 1, 32'h80); tick(); resolve_valid = 0; #1;
    vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL floor_after_taken: got %b want 0", pred_taken); end
    bp_hit = 0;
  endtask

  task automatic test_back_to_back;
    do_reset(); ihit = 1;
    drive_resolve(32'h8, 1, 32'h300, 0, 32'h0); tick();
    drive_resolve(32'h300, 1, 32'hFFFF_FFFC, 0, 32'h0); #1;
    vectors++; if (mispredict !== 1'b1 || imemREN !== 1'b0 || imemaddr !== 32'h300) begin miscompares++; $display("FAIL b2b_second: got mp=%b ren=%b pc=%h want 1 0 300", mispredict, imemREN, imemaddr); end
    tick(); resolve_valid = 0; #1;
    vectors++; if (imemaddr !== 32'hFFFF_FFFC || imemREN !== 1'b0) begin miscompares++; $display("FAIL b2b_redir: got pc=%h ren=%b want fffffffc 0", imemaddr, imemREN); end
    tick(); #1;
    vectors++; if (fetch_npc !== 32'h0 || fetch_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_npc: got npc=%h fv=%b want 0 1", fetch_npc, fetch_valid); end
    tick(); #1;
    vectors++; if (imemaddr !== 32'h0) begin miscompares++; $display("FAIL wrap_pc: got %h want %h", imemaddr, 32'h0); end
    drive_resolve(32'h8, 1, 32'h300, 0, 32'h0); tick();
    RST = 1; drive_resolve(32'h300, 1, 32'h700, 0, 32'h0); tick();
    RST = 0; resolve_valid = 0; #1;
    vectors++; if (imemaddr !== 32'h0 || imemREN !== 1'b1) begin miscompares++; $display("FAIL rst_in_redirect: got pc=%h ren=%b want 0 1", imemaddr, imemREN); end
    ihit = 0;
  endtask

  task automatic test_halt;
    do_reset(); ihit = 1; tick(); tick(); ihit = 0;
    drive_resolve(32'h10, 1, 32'h200, 0, 32'h0); halt = 1; #1;
    vectors++; if (mispredict !== 1'b0) begin miscompares++; $display("FAIL halt_mp: got %b want 0", mispredict); end
    tick(); halt = 0; resolve_valid = 0; #1;
    vectors++; if (imemREN !== 1'b0 || imemaddr !== 32'h8) begin miscompares++; $display("FAIL halt_state: got ren=%b pc=%h want 0 8", imemREN, imemaddr); end
    ihit = 1; drive_resolve(32'h10, 1, 32'h200, 0, 32'h0); #1;
    vectors++; if (mispredict !== 1'b0 || fetch_valid !== 1'b0) begin miscompares++; $display("FAIL halt_hold: got mp=%b fv=%b want 0 0", mispredict, fetch_valid); end
    tick(); tick(); resolve_valid = 0; #1;
    vectors++; if (imemaddr !== 32'h8 || imemREN !== 1'b0) begin miscompares++; $display("FAIL halt_frozen: got pc=%h ren=%b want 8 0", imemaddr, imemREN); end
    RST = 1; ihit = 0; tick(); RST = 0; #1;
    vectors++; if (imemaddr !== 32'h0 || imemREN !== 1'b1) begin miscompares++; $display("FAIL halt_exit: got pc=%h ren=%b want 0 1", imemaddr, imemREN); end
  endtask

  initial begin
    RST = 1; idle_inputs();
    test_reset();
    test_sequential();
    test_predict();
    test_mispredict();
    test_stall();
    test_ctr_floor();
    test_back_to_back();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
